// File: rtl/router_ingress_ctrl.sv
// Source-side ingress controller for the 1xN packet router: steers byte-serial
// packets into per-port FIFOs, checks length/parity, drops bad addresses.
module router_ingress_ctrl #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] fifo_we,
  output logic [DATA_W-1:0]    fifo_wdata,
  output logic                 pkt_done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [2:0]           dbg_state
);

  localparam int LEN_W = DATA_W - ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_PARITY  = 3'd2,
    S_DROP    = 3'd3,
    S_CHECK   = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   dest;
  logic [LEN_W-1:0]    count;
  logic [DATA_W-1:0]   par;
  logic                pend_addr, pend_len, pend_par;

  logic [ADDR_W-1:0]   hdr_addr;
  logic [LEN_W-1:0]    hdr_len;
  logic                addr_ok;
  logic                full_hdr, full_dest;
  logic                accept, write;
  logic [ADDR_W-1:0]   wr_port;

  assign hdr_addr   = data_in[ADDR_W-1:0];
  assign hdr_len    = data_in[DATA_W-1:ADDR_W];
  assign addr_ok    = (32'(hdr_addr) < 32'(NUM_PORTS));
  assign fifo_wdata = data_in;
  assign pkt_done   = (state == S_CHECK);
  assign dbg_state  = state;

  // Full flag of the header's port and of the latched destination.
  always_comb begin
    full_hdr  = 1'b0;
    full_dest = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (hdr_addr == ADDR_W'(i)) full_hdr  = fifo_full[i];
      if (dest     == ADDR_W'(i)) full_dest = fifo_full[i];
    end
  end

  // Handshake: a beat transfers on a clock edge where busy=0 and the beat
  // qualifies for the current state; the source holds the beat while busy=1.
  always_comb begin
    busy       = 1'b0;
    accept     = 1'b0;
    write      = 1'b0;
    wr_port    = dest;
    state_next = state;
    case (state)
      S_IDLE: begin
        wr_port = hdr_addr;
        busy    = pkt_valid & addr_ok & full_hdr;
        accept  = pkt_valid & ~busy;
        write   = accept & addr_ok;
        if (accept) begin
          if (!addr_ok)           state_next = S_DROP;
          else if (hdr_len != '0) state_next = S_PAYLOAD;
          else                    state_next = S_PARITY;
        end
      end
      S_PAYLOAD: begin
        busy   = full_dest;
        accept = ~busy;
        write  = accept;
        if (accept) begin
          if (!pkt_valid)                    state_next = S_CHECK;
          else if (count == LEN_W'(1))       state_next = S_PARITY;
        end
      end
      S_PARITY: begin
        busy   = full_dest;
        accept = ~busy;
        write  = accept & ~pkt_valid;
        if (accept) state_next = pkt_valid ? S_DROP : S_CHECK;
      end
      S_DROP: begin
        accept = 1'b1;
        if (!pkt_valid) state_next = S_CHECK;
      end
      S_CHECK: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (!resetn) begin
      busy   = 1'b0;
      accept = 1'b0;
      write  = 1'b0;
    end
  end

  always_comb begin
    fifo_we = '0;
    for (int i = 0; i < NUM_PORTS; i++) fifo_we[i] = write & (wr_port == ADDR_W'(i));
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      dest      <= '0;
      count     <= '0;
      par       <= '0;
      pend_addr <= 1'b0;
      pend_len  <= 1'b0;
      pend_par  <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (accept) begin
          error    <= 1'b0;
          err_code <= 2'd0;
          dest     <= hdr_addr;
          count    <= hdr_len;
          par      <= data_in;
          if (!addr_ok) pend_addr <= 1'b1;
        end
        S_PAYLOAD: if (accept) begin
          if (pkt_valid) begin
            par   <= par ^ data_in;
            count <= count - LEN_W'(1);
          end else begin
            pend_len <= 1'b1;
          end
        end
        S_PARITY: if (accept) begin
          if (pkt_valid)             pend_len <= 1'b1;
          else if (data_in != par)   pend_par <= 1'b1;
        end
        S_CHECK: begin
          error <= pend_addr | pend_len | pend_par;
          // Address outranks length, which outranks parity.
          if (pend_addr)     err_code <= 2'd2;
          else if (pend_len) err_code <= 2'd3;
          else if (pend_par) err_code <= 2'd1;
          else               err_code <= 2'd0;
          pend_addr <= 1'b0;
          pend_len  <= 1'b0;
          pend_par  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Bench for router_ingress_ctrl: directed vector table, hand-written corner
// sequences and randomized packets against a packet-level reference model.
module tb_router_ingress_ctrl;

  localparam int NUM_PORTS = 3;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic       busy;
  logic [2:0] fifo_we;
  logic [7:0] fifo_wdata;
  logic       pkt_done;
  logic       error;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  router_ingress_ctrl #(.DATA_W(8), .NUM_PORTS(NUM_PORTS), .ADDR_W(2)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .busy(busy), .fifo_we(fifo_we), .fifo_wdata(fifo_wdata),
    .pkt_done(pkt_done), .error(error), .err_code(err_code), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  bit rand_full = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write is sampled just before the edge that commits it.
  always @(negedge clock) begin
    #4;
    if (fifo_we !== 3'b000) begin
      logic [15:0] e;
      int p;
      p = 0;
      for (int i = 0; i < NUM_PORTS; i++) if (fifo_we[i]) p = i;
      checks++;
      wr_cnt++;
      if (!$onehot(fifo_we)) begin
        errors++;
        $display("FAIL write_onehot: got %b expected one-hot", fifo_we);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got port %0d data %0h expected none", p, fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({8'(p), fifo_wdata} !== e) begin
          errors++;
          $display("FAIL write_data: got port %0d data %0h expected port %0d data %0h",
                   p, fifo_wdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] hdr_buf;
  logic [7:0] pay_buf[8];
  int         npay;
  logic [7:0] par_buf;

  // Packet-level rules: bad address writes nothing; a short packet writes all
  // its beats; a long one is cut after the declared payload; parity is the
  // XOR of header and payload.
  task automatic model_packet(output int code, output int nwr);
    int addr, len, k;
    logic [7:0] x;
    addr = int'(hdr_buf[1:0]);
    len  = int'(hdr_buf[7:2]);
    nwr  = 0;
    if (addr >= NUM_PORTS) begin
      code = 2;
      return;
    end
    exp_q.push_back({8'(addr), hdr_buf});
    nwr = 1;
    x = hdr_buf;
    k = (npay < len) ? npay : len;
    for (int i = 0; i < k; i++) begin
      exp_q.push_back({8'(addr), pay_buf[i]});
      x ^= pay_buf[i];
      nwr++;
    end
    if (npay > len) begin
      code = 3;
    end else begin
      exp_q.push_back({8'(addr), par_buf});
      nwr++;
      if (npay < len)         code = 3;
      else if (x != par_buf)  code = 1;
      else                    code = 0;
    end
  endtask

  // ---------------- driver tasks (start and end just after a negedge) ----------------
  task automatic send_beat(input logic v, input logic [7:0] d);
    int  stalls;
    bit  done;
    stalls = 0;
    done   = 0;
    pkt_valid = v;
    data_in   = d;
    while (!done) begin
      if (rand_full) fifo_full = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      #4;
      if (!busy) done = 1;
      else stalls++;
      @(negedge clock);
      if (!done && stalls > 500) begin
        chk("beat_timeout", 32'(stalls), 32'd0);
        done = 1;
      end
    end
  endtask

  task automatic finish_packet(input int exp_code, input int exp_wr, input int w0);
    #4;
    chk("pkt_done_high", pkt_done, 1);
    chk("check_busy", busy, 1);
    @(negedge clock);
    chk("error", error, (exp_code != 0));
    chk("err_code", err_code, exp_code);
    chk("pkt_done_low", pkt_done, 0);
    chk("write_count", 32'(wr_cnt - w0), 32'(exp_wr));
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic run_packet(input int exp_code, input int exp_wr);
    int w0;
    w0 = wr_cnt;
    send_beat(1'b1, hdr_buf);
    chk("hdr_clears_error", {error, err_code}, 3'b000);
    for (int i = 0; i < npay; i++) send_beat(1'b1, pay_buf[i]);
    send_beat(1'b0, par_buf);
    finish_packet(exp_code, exp_wr, w0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] pay;    // byte i in bits [8*i +: 8]
    int          npay;
    logic [7:0]  par;
    int          exp_code;
    int          exp_wr;
  } vec_t;

  vec_t vecs[7];

  task automatic load_vec(input vec_t v);
    hdr_buf = v.hdr;
    npay    = v.npay;
    par_buf = v.par;
    for (int i = 0; i < 4; i++) pay_buf[i] = v.pay[8*i +: 8];
  endtask

  initial begin
    int code, nwr, w0;

    vecs[0] = '{8'h11, 32'h04030201, 4, 8'h15, 0, 6};  // good packet, port 1
    vecs[1] = '{8'h0A, 32'h000055AA, 2, 8'h00, 1, 4};  // bad parity, port 2
    vecs[2] = '{8'h0B, 32'h00002211, 2, 8'h33, 2, 0};  // address 3 dropped
    vecs[3] = '{8'h06, 32'h00002211, 2, 8'h00, 3, 2};  // long packet
    vecs[4] = '{8'h02, 32'h00000000, 0, 8'h02, 0, 2};  // zero-length
    vecs[5] = '{8'h11, 32'h00000201, 2, 8'h00, 3, 4};  // short packet
    vecs[6] = '{8'h00, 32'h00000000, 0, 8'h00, 0, 2};  // zero-length, port 0

    resetn    = 1'b0;
    pkt_valid = 1'b1;
    data_in   = 8'h11;
    fifo_full = 3'b010;
    @(negedge clock);
    #4;
    chk("reset_busy", busy, 0);
    chk("reset_we", fifo_we, 0);
    @(negedge clock);
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    fifo_full = 3'b000;
    #4;
    chk("reset_error", error, 0);
    chk("reset_err_code", err_code, 0);
    chk("reset_pkt_done", pkt_done, 0);
    @(negedge clock);

    for (int v = 0; v < 7; v++) begin
      load_vec(vecs[v]);
      model_packet(code, nwr);
      run_packet(vecs[v].exp_code, vecs[v].exp_wr);
    end

    // Back-pressure: port 1 full for three cycles after the second payload beat.
    load_vec(vecs[0]);
    model_packet(code, nwr);
    w0 = wr_cnt;
    send_beat(1'b1, 8'h11);
    send_beat(1'b1, 8'h01);
    send_beat(1'b1, 8'h02);
    pkt_valid = 1'b1;
    data_in   = 8'h03;
    fifo_full = 3'b010;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk("bp_busy", busy, 1);
      chk("bp_no_write", fifo_we, 0);
      @(negedge clock);
    end
    fifo_full = 3'b000;
    #4;
    chk("bp_released", busy, 0);
    @(negedge clock);
    send_beat(1'b1, 8'h04);
    send_beat(1'b0, 8'h15);
    finish_packet(0, 6, w0);

    // Other ports full must not stall a packet to port 2.
    fifo_full = 3'b011;
    load_vec(vecs[4]);
    model_packet(code, nwr);
    run_packet(0, 2);
    fifo_full = 3'b000;

    // Reset in the middle of the payload abandons the packet.
    exp_q.push_back({8'd1, 8'h11});
    exp_q.push_back({8'd1, 8'h01});
    exp_q.push_back({8'd1, 8'h02});
    send_beat(1'b1, 8'h11);
    send_beat(1'b1, 8'h01);
    send_beat(1'b1, 8'h02);
    resetn    = 1'b0;
    pkt_valid = 1'b1;
    data_in   = 8'h03;
    #4;
    chk("mid_reset_we", fifo_we, 0);
    chk("mid_reset_busy", busy, 0);
    @(negedge clock);
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    #4;
    chk("mid_reset_error", {error, err_code}, 3'b000);
    chk("mid_reset_pkt_done", pkt_done, 0);
    chk("mid_reset_queue", 32'(exp_q.size()), 0);
    @(negedge clock);
    load_vec(vecs[0]);
    model_packet(code, nwr);
    run_packet(0, 6);

    // Randomized packets with random FIFO back-pressure.
    rand_full = 1;
    for (int n = 0; n < 60; n++) begin
      int addr, len, r;
      logic [7:0] x;
      addr = $urandom_range(0, 3);
      len  = $urandom_range(0, 5);
      r    = $urandom_range(0, 9);
      if (r == 0 && len > 0) npay = len - 1;
      else if (r == 1)       npay = len + 1;
      else                   npay = len;
      hdr_buf = {6'(len), 2'(addr)};
      x = hdr_buf;
      for (int i = 0; i < npay; i++) begin
        pay_buf[i] = 8'($urandom_range(0, 255));
        x ^= pay_buf[i];
      end
      par_buf = x;
      if ($urandom_range(0, 3) == 0) par_buf = par_buf ^ (8'd1 << $urandom_range(0, 7));
      model_packet(code, nwr);
      run_packet(code, nwr);
    end
    rand_full = 0;
    fifo_full = 3'b000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
